// File: rtl/tri_hit_reducer.sv
// tri_hit_reducer
//   Closest-hit reduction of one ray against a batch of triangles. Results
//   arrive as beats of LANES parallel intersection results. The reducer keeps
//   the nearest qualifying hit inside the window [min_t, max_t). It presents
//   that hit on a valid/ready result port.
//
// Ports
//   i_clk, i_rstn         clock, synchronous active-low reset
//   i_start, i_tri_cnt    batch start and triangle count (sampled in IDLE)
//   i_min_t, i_max_t      signed t window, inclusive low / exclusive high
//   i_abort               drop the current batch (RUN or DONE), no result
//   i_res_valid/o_res_ready  result beat handshake
//   i_res_hit, i_res_t    per-lane hit flags and t values (lane k at k*W)
//   i_res_base            triangle index of lane 0 (lane k = base + k)
//   o_out_valid/i_out_ready  reduced result handshake
//   o_hit, o_t, o_tri_index  closest hit flag, t and triangle index
//   o_busy                high while a batch is in RUN or DONE
module tri_hit_reducer #(
    parameter int LANES = 4,
    parameter int W     = 32,
    parameter int CW    = 32
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_start,
    input  logic [CW-1:0]      i_tri_cnt,
    input  logic [W-1:0]       i_min_t,
    input  logic [W-1:0]       i_max_t,
    input  logic               i_abort,
    input  logic               i_res_valid,
    output logic               o_res_ready,
    input  logic [LANES-1:0]   i_res_hit,
    input  logic [LANES*W-1:0] i_res_t,
    input  logic [CW-1:0]      i_res_base,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic               o_hit,
    output logic [W-1:0]       o_t,
    output logic [CW-1:0]      o_tri_index,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       rem_q, rem_d;
    logic [CW-1:0]       best_idx_q, best_idx_d;
    logic signed [W-1:0] min_t_q, min_t_d;
    logic signed [W-1:0] best_t_q, best_t_d;
    logic                hit_q, hit_d;

    logic                accept;
    logic                last_beat;
    logic [CW-1:0]       used;
    logic signed [W-1:0] lane_t;
    logic signed [W-1:0] scan_t;
    logic [CW-1:0]       scan_idx;
    logic                scan_hit;

    assign o_res_ready = (state_q == S_RUN);
    assign o_out_valid = (state_q == S_DONE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_hit       = hit_q;
    assign o_t         = best_t_q;
    assign o_tri_index = best_idx_q;

    // Abort wins over a beat presented in the same cycle.
    assign accept    = o_res_ready && i_res_valid && !i_abort;
    assign used      = (rem_q > CW'(LANES)) ? CW'(LANES) : rem_q;
    assign last_beat = (rem_q <= CW'(LANES));

    // Walking lanes in ascending order with a strict '<' against the running
    // best gives lowest-t-wins with ties going to the lower lane. It also
    // lets an earlier beat keep a tie against a later one.
    always_comb begin
        scan_t   = best_t_q;
        scan_idx = best_idx_q;
        scan_hit = hit_q;
        lane_t   = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_t = i_res_t[W*k +: W];
            if ((CW'(k) < rem_q) && i_res_hit[k] &&
                (lane_t >= min_t_q) && (lane_t < scan_t)) begin
                scan_t   = lane_t;
                scan_idx = i_res_base + CW'(k);
                scan_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        best_idx_d = best_idx_q;
        min_t_d    = min_t_q;
        best_t_d   = best_t_q;
        hit_d      = hit_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    rem_d      = i_tri_cnt;
                    min_t_d    = i_min_t;
                    best_t_d   = i_max_t;
                    best_idx_d = '0;
                    hit_d      = 1'b0;
                    state_d    = (i_tri_cnt == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    best_t_d   = scan_t;
                    best_idx_d = scan_idx;
                    hit_d      = scan_hit;
                    rem_d      = rem_q - used;
                    if (last_beat) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (i_abort || i_out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            best_idx_q <= '0;
            min_t_q    <= '0;
            best_t_q   <= '0;
            hit_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            best_idx_q <= best_idx_d;
            min_t_q    <= min_t_d;
            best_t_q   <= best_t_d;
            hit_q      <= hit_d;
        end
    end

endmodule
